// File: rtl/eth_tx_clk_ctrl_if.sv
// Speed-change request channel between the link/MDIO logic and the TX clock controller.
// A request transfers on a cycle with speed_valid && speed_ready; speed_req must stay stable while waiting.
interface eth_tx_clk_ctrl_if;
  logic [1:0] speed_req;
  logic       speed_valid;
  logic       speed_ready;

  modport master (output speed_req, output speed_valid, input speed_ready);
  modport slave  (input speed_req, input speed_valid, output speed_ready);
endinterface

// File: rtl/eth_tx_clk_ctrl.sv
// Ethernet TX clock controller: divided 2.5/25 MHz clock and enable, or gigabit select,
// with glitch-free speed changes (drain current period, quiet gap, start new rate).
module eth_tx_clk_ctrl #(
  parameter int DIV_10       = 50,
  parameter int DIV_100      = 5,
  parameter int QUIET_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic                rx_clk125,
  input  logic                rst,
  eth_tx_clk_ctrl_if.slave    req_if,
  output logic                tx_clk_div,
  output logic                tx_ce,
  output logic                gtx_sel,
  output logic [1:0]          speed_cur,
  output logic                switching,
  output logic                bad_req,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, QUIET = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_10    = CNT_W'(DIV_10 - 1);
  localparam logic [CNT_W-1:0] LAST_100   = CNT_W'(DIV_100 - 1);
  localparam logic [CNT_W-1:0] HALF_10    = CNT_W'(DIV_10 / 2);
  localparam logic [CNT_W-1:0] HALF_100   = CNT_W'(DIV_100 / 2);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       target;
  logic             ready_q;
  logic [CNT_W-1:0] last_sel;
  logic [CNT_W-1:0] half_sel;
  logic             gig;
  logic             wrap;

  assign req_if.speed_ready = ready_q;
  assign state_dbg          = state;

  always_comb begin
    last_sel = LAST_100;
    half_sel = HALF_100;
    if (speed_cur == 2'b00) begin
      last_sel = LAST_10;
      half_sel = HALF_10;
    end
    gig  = (speed_cur == 2'b10);
    // >= rather than == so a corrupted counter still wraps within one period
    wrap = (cnt >= last_sel);
  end

  always_ff @(posedge rx_clk125) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      target     <= 2'b00;
      speed_cur  <= 2'b00;
      tx_clk_div <= 1'b0;
      tx_ce      <= 1'b0;
      gtx_sel    <= 1'b0;
      ready_q    <= 1'b1;
      switching  <= 1'b0;
      bad_req    <= 1'b0;
    end else begin
      bad_req <= 1'b0;
      case (state)
        RUN: begin
          if (gig) begin
            tx_clk_div <= 1'b0;
            tx_ce      <= 1'b1;
            gtx_sel    <= 1'b1;
            cnt        <= '0;
          end else begin
            tx_clk_div <= (cnt < half_sel);
            tx_ce      <= (cnt == '0);
            gtx_sel    <= 1'b0;
            cnt        <= wrap ? '0 : cnt + 1'b1;
          end
          if (req_if.speed_valid && ready_q) begin
            if (req_if.speed_req == 2'b11) begin
              bad_req <= 1'b1;
            end else if (req_if.speed_req != speed_cur) begin
              target    <= req_if.speed_req;
              state     <= DRAIN;
              ready_q   <= 1'b0;
              switching <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // The terminal cycle is already in the low phase, so forcing outputs low here
          // keeps the gigabit select from leaking into the quiet interval.
          if (gig || wrap) begin
            tx_clk_div <= 1'b0;
            tx_ce      <= 1'b0;
            gtx_sel    <= 1'b0;
            cnt        <= '0;
            state      <= QUIET;
          end else begin
            tx_clk_div <= (cnt < half_sel);
            tx_ce      <= (cnt == '0);
            gtx_sel    <= 1'b0;
            cnt        <= cnt + 1'b1;
          end
        end
        QUIET: begin
          tx_clk_div <= 1'b0;
          tx_ce      <= 1'b0;
          gtx_sel    <= 1'b0;
          if (cnt >= QUIET_LAST) begin
            speed_cur <= target;
            cnt       <= '0;
            state     <= RUN;
            switching <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_clk_ctrl.sv
// Directed bench for eth_tx_clk_ctrl: cycle-exact timelines of rate output, switching and handshake.
module tb_eth_tx_clk_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_clk_div;
  logic       tx_ce;
  logic       gtx_sel;
  logic [1:0] speed_cur;
  logic       switching;
  logic       bad_req;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         failures = 0;

  eth_tx_clk_ctrl_if bus ();

  eth_tx_clk_ctrl dut (
    .rx_clk125  (clk),
    .rst        (rst),
    .req_if     (bus.slave),
    .tx_clk_div (tx_clk_div),
    .tx_ce      (tx_ce),
    .gtx_sel    (gtx_sel),
    .speed_cur  (speed_cur),
    .switching  (switching),
    .bad_req    (bad_req),
    .state_dbg  (state_dbg)
  );

  always #4 clk = ~clk;

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: reset values visible, rst low from here on.
  task automatic do_reset();
    rst = 1'b1;
    bus.speed_valid = 1'b0;
    bus.speed_req = 2'b00;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // 10M -> 100M switch accepted in cycle 0; ends in cycle 58, first 100M RUN cycle (counter 0).
  task automatic run_to_100();
    do_reset();
    bus.speed_valid = 1'b1;
    bus.speed_req = 2'b01;
    step();
    bus.speed_valid = 1'b0;
    repeat (57) step();
  endtask

  task automatic test_reset();
    logic [9:0] exp_v;
    do_reset();
    exp_v = {3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0};
    checks++;
    if ({tx_clk_div, tx_ce, gtx_sel, speed_cur, bus.speed_ready, switching, bad_req, state_dbg} !== exp_v) begin
      failures++;
      $display("FAIL reset_values got=%b want=%b", {tx_clk_div, tx_ce, gtx_sel, speed_cur, bus.speed_ready, switching, bad_req, state_dbg}, exp_v);
    end
  endtask

  task automatic test_idle_10m();
    int m;
    logic [2:0] exp_o;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      step();
      m = (k - 1) % 50;
      exp_o = {(m < 25), (m == 0), 1'b0};
      checks++;
      if ({tx_clk_div, tx_ce, gtx_sel} !== exp_o) begin
        failures++;
        $display("FAIL idle_10m cyc=%0d got=%b want=%b", k, {tx_clk_div, tx_ce, gtx_sel}, exp_o);
      end
      checks++;
      if (speed_cur !== 2'b00) begin
        failures++;
        $display("FAIL idle_speed cyc=%0d got=%b want=00", k, speed_cur);
      end
    end
  endtask

  task automatic test_switch_10_to_100();
    int m;
    logic [2:0] exp_o;
    logic [1:0] exp_st;
    do_reset();
    repeat (10) step();
    bus.speed_valid = 1'b1;
    bus.speed_req = 2'b01;
    step();
    bus.speed_valid = 1'b0;
    checks++;
    if ({switching, bus.speed_ready, state_dbg} !== {1'b1, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL accept_01 got sw/rdy/st=%b want=1001", {switching, bus.speed_ready, state_dbg});
    end
    for (int k = 12; k <= 57; k++) begin
      step();
      m = (k - 1) % 50;
      exp_o = (k <= 49) ? {(m < 25), (m == 0), 1'b0} : 3'b000;
      exp_st = (k <= 49) ? 2'd1 : 2'd2;
      checks++;
      if ({tx_clk_div, tx_ce, gtx_sel, state_dbg, speed_cur, bus.speed_ready, switching} !== {exp_o, exp_st, 2'b00, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL drain_quiet_10 cyc=%0d got=%b want=%b", k, {tx_clk_div, tx_ce, gtx_sel, state_dbg, speed_cur, bus.speed_ready, switching}, {exp_o, exp_st, 2'b00, 1'b0, 1'b1});
      end
    end
    step();
    checks++;
    if ({tx_clk_div, tx_ce, gtx_sel, state_dbg, speed_cur, bus.speed_ready, switching} !== {3'b000, 2'd0, 2'b01, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL run_entry_100 got=%b want=%b", {tx_clk_div, tx_ce, gtx_sel, state_dbg, speed_cur, bus.speed_ready, switching}, {3'b000, 2'd0, 2'b01, 1'b1, 1'b0});
    end
    for (int j = 1; j <= 20; j++) begin
      step();
      m = (j - 1) % 5;
      exp_o = {(m < 2), (m == 0), 1'b0};
      checks++;
      if ({tx_clk_div, tx_ce, gtx_sel} !== exp_o) begin
        failures++;
        $display("FAIL run_100 j=%0d got=%b want=%b", j, {tx_clk_div, tx_ce, gtx_sel}, exp_o);
      end
    end
  endtask

  task automatic test_switch_100_to_1000();
    logic [2:0] exp_o;
    logic [1:0] exp_st;
    logic [1:0] exp_spd;
    run_to_100();
    bus.speed_valid = 1'b1;
    bus.speed_req = 2'b10;
    for (int i = 1; i <= 30; i++) begin
      step();
      bus.speed_valid = 1'b0;
      if (i <= 4) begin
        exp_o = {(i - 1 < 2), (i == 1), 1'b0};
        exp_st = 2'd1;
      end else if (i <= 12) begin
        exp_o = 3'b000;
        exp_st = 2'd2;
      end else begin
        exp_o = (i == 13) ? 3'b000 : 3'b011;
        exp_st = 2'd0;
      end
      exp_spd = (i >= 13) ? 2'b10 : 2'b01;
      checks++;
      if ({tx_clk_div, tx_ce, gtx_sel, state_dbg, speed_cur} !== {exp_o, exp_st, exp_spd}) begin
        failures++;
        $display("FAIL switch_100_1000 i=%0d got=%b want=%b", i, {tx_clk_div, tx_ce, gtx_sel, state_dbg, speed_cur}, {exp_o, exp_st, exp_spd});
      end
      checks++;
      if ((gtx_sel && tx_clk_div) || (gtx_sel && state_dbg == 2'd2)) begin
        failures++;
        $display("FAIL gtx_overlap i=%0d got gtx=%b div=%b st=%0d want no overlap", i, gtx_sel, tx_clk_div, state_dbg);
      end
    end
  endtask

  task automatic test_same_and_reserved();
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      bus.speed_valid = (k < 2);
      bus.speed_req = (k == 0) ? 2'b00 : 2'b11;
      step();
      checks++;
      if ({bad_req, bus.speed_ready, switching, speed_cur, state_dbg} !== {(k + 1 == 2), 1'b1, 1'b0, 2'b00, 2'd0}) begin
        failures++;
        $display("FAIL same_reserved cyc=%0d got=%b want=%b", k + 1, {bad_req, bus.speed_ready, switching, speed_cur, state_dbg}, {(k + 1 == 2), 1'b1, 1'b0, 2'b00, 2'd0});
      end
    end
    bus.speed_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.speed_valid = 1'b1;
    bus.speed_req = 2'b01;
    step();
    bus.speed_req = 2'b10;
    for (int k = 1; k <= 58; k++) begin
      if (k > 1) step();
      checks++;
      if ({bus.speed_ready, speed_cur} !== {(k == 58), ((k == 58) ? 2'b01 : 2'b00)}) begin
        failures++;
        $display("FAIL held_req cyc=%0d got rdy/spd=%b want=%b", k, {bus.speed_ready, speed_cur}, {(k == 58), ((k == 58) ? 2'b01 : 2'b00)});
      end
    end
    step();
    bus.speed_valid = 1'b0;
    checks++;
    if ({switching, bus.speed_ready, state_dbg, speed_cur} !== {1'b1, 1'b0, 2'd1, 2'b01}) begin
      failures++;
      $display("FAIL second_accept got=%b want=%b", {switching, bus.speed_ready, state_dbg, speed_cur}, {1'b1, 1'b0, 2'd1, 2'b01});
    end
    repeat (12) step();
    checks++;
    if ({state_dbg, speed_cur, bus.speed_ready, switching} !== {2'd0, 2'b10, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL second_done got=%b want=%b", {state_dbg, speed_cur, bus.speed_ready, switching}, {2'd0, 2'b10, 1'b1, 1'b0});
    end
    step();
    checks++;
    if ({tx_clk_div, tx_ce, gtx_sel} !== 3'b011) begin
      failures++;
      $display("FAIL gig_after_b2b got=%b want=011", {tx_clk_div, tx_ce, gtx_sel});
    end
  endtask

  task automatic test_reset_mid_quiet();
    int m;
    logic [2:0] exp_o;
    do_reset();
    bus.speed_valid = 1'b1;
    bus.speed_req = 2'b10;
    step();
    bus.speed_valid = 1'b0;
    repeat (52) step();
    checks++;
    if (state_dbg !== 2'd2) begin
      failures++;
      $display("FAIL in_quiet got=%0d want=2", state_dbg);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({tx_clk_div, tx_ce, gtx_sel, speed_cur, bus.speed_ready, switching, bad_req, state_dbg} !== {3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_mid_quiet got=%b want=%b", {tx_clk_div, tx_ce, gtx_sel, speed_cur, bus.speed_ready, switching, bad_req, state_dbg}, {3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0});
    end
    for (int j = 1; j <= 100; j++) begin
      step();
      m = (j - 1) % 50;
      exp_o = {(m < 25), (m == 0), 1'b0};
      checks++;
      if ({tx_clk_div, tx_ce, gtx_sel, state_dbg, switching, speed_cur} !== {exp_o, 2'd0, 1'b0, 2'b00}) begin
        failures++;
        $display("FAIL restart_10m j=%0d got=%b want=%b", j, {tx_clk_div, tx_ce, gtx_sel, state_dbg, switching, speed_cur}, {exp_o, 2'd0, 1'b0, 2'b00});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.speed_valid = 1'b0;
    bus.speed_req = 2'b00;
    test_reset();
    test_idle_10m();
    test_switch_10_to_100();
    test_switch_100_to_1000();
    test_same_and_reserved();
    test_back_to_back();
    test_reset_mid_quiet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
